// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction queue, two pushes and one show-ahead pop per cycle
module inst_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push0_valid,
    input  logic [31:0]       push0_pc,
    input  logic [31:0]       push0_instr,
    input  logic              push0_adel,
    input  logic              push1_valid,
    input  logic [31:0]       push1_pc,
    input  logic [31:0]       push1_instr,
    input  logic              push1_adel,
    output logic              fifo_ready,
    input  logic              pop_ready,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic              out_adel,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W:0] READY_MAX = (ADDR_W + 1)'(DEPTH - 2);

    logic [31:0]       pcMem    [DEPTH];
    logic [31:0]       instrMem [DEPTH];
    logic              adelMem  [DEPTH];

    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [ADDR_W-1:0] wrPtrPlus1;
    logic [ADDR_W-1:0] wrPtrNext;
    logic [ADDR_W-1:0] rdPtrNext;
    logic [ADDR_W:0]   pushCnt;
    logic [ADDR_W:0]   countNext;
    logic              write0;
    logic              write1;
    logic              popFire;
    logic              headAdel;

    // Readiness looks only at the registered count so pop_ready never reaches fifo_ready.
    assign fifo_ready = (count <= READY_MAX);

    // Slot 1 rides on slot 0; a lone slot 1 is a writer bug and is dropped.
    assign write0     = fifo_ready & push0_valid & ~flush;
    assign write1     = write0 & push1_valid;

    assign out_valid  = (count != '0);
    assign popFire    = out_valid & pop_ready;

    assign wrPtrPlus1 = wrPtr + ADDR_W'(1);

    always_comb begin
        pushCnt = '0;
        if (write1) begin
            pushCnt = (ADDR_W + 1)'(2);
        end else if (write0) begin
            pushCnt = (ADDR_W + 1)'(1);
        end
    end

    assign countNext = count + pushCnt - (ADDR_W + 1)'(popFire);
    assign wrPtrNext = wrPtr + ADDR_W'(pushCnt);
    assign rdPtrNext = popFire ? (rdPtr + ADDR_W'(1)) : rdPtr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= wrPtrNext;
            rdPtr <= rdPtrNext;
            count <= countNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pcMem[i]    <= '0;
                instrMem[i] <= '0;
                adelMem[i]  <= 1'b0;
            end
        end else begin
            if (write0) begin
                pcMem[wrPtr]    <= push0_pc;
                instrMem[wrPtr] <= push0_instr;
                adelMem[wrPtr]  <= push0_adel;
            end
            if (write1) begin
                pcMem[wrPtrPlus1]    <= push1_pc;
                instrMem[wrPtrPlus1] <= push1_instr;
                adelMem[wrPtrPlus1]  <= push1_adel;
            end
        end
    end

    // A faulting fetch or an empty queue hands the decoder a NOP instead of garbage.
    assign headAdel = adelMem[rdPtr];

    always_comb begin
        out_pc    = pcMem[rdPtr];
        out_adel  = headAdel;
        out_instr = '0;
        if (out_valid && !headAdel) begin
            out_instr = instrMem[rdPtr];
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed and randomized check of inst_queue against a queue model
module tb_inst_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          push0_valid = 1'b0;
    logic [31:0]   push0_pc = '0;
    logic [31:0]   push0_instr = '0;
    logic          push0_adel = 1'b0;
    logic          push1_valid = 1'b0;
    logic [31:0]   push1_pc = '0;
    logic [31:0]   push1_instr = '0;
    logic          push1_adel = 1'b0;
    logic          fifo_ready;
    logic          pop_ready = 1'b0;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_adel;
    logic [AW:0]   count;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push0_valid (push0_valid),
        .push0_pc    (push0_pc),
        .push0_instr (push0_instr),
        .push0_adel  (push0_adel),
        .push1_valid (push1_valid),
        .push1_pc    (push1_pc),
        .push1_instr (push1_instr),
        .push1_adel  (push1_adel),
        .fifo_ready  (fifo_ready),
        .pop_ready   (pop_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_adel    (out_adel),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ent_t;

    ent_t mq[$];
    int   mWr = 0;
    int   total = 0;
    int   bad = 0;
    bit   cmpEn = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelPush();
        mq.push_back({push0_pc, push0_instr, push0_adel});
        if (push1_valid) mq.push_back({push1_pc, push1_instr, push1_adel});
        mWr <= (mWr + (push1_valid ? 2 : 1)) % DEPTH;
    endtask

    // Queue model: pop the front if anything is there, append accepted slots at the back.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mWr <= 0;
        end else if (flush) begin
            mq.delete();
            mWr <= 0;
        end else if (mq.size() != 0 && pop_ready) begin
            void'(mq.pop_front());
            if (mq.size() + 1 <= DEPTH - 2 && push0_valid) modelPush();
        end else if (mq.size() <= DEPTH - 2 && push0_valid) begin
            modelPush();
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            check("m_valid", 64'(out_valid), 64'(mq.size() != 0));
            check("m_count", 64'(count), 64'(mq.size()));
            check("m_ready", 64'(fifo_ready), 64'(mq.size() <= DEPTH - 2));
            check("m_wrptr", 64'(dut.wrPtr), 64'(mWr));
            if (mq.size() != 0) begin
                check("m_pc", 64'(out_pc), 64'(mq[0].pc));
                check("m_adel", 64'(out_adel), 64'(mq[0].adel));
                check("m_instr", 64'(out_instr), mq[0].adel ? 64'(0) : 64'(mq[0].instr));
            end else begin
                check("m_instr_empty", 64'(out_instr), 64'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0;
        push0_valid = 1'b0;
        push1_valid = 1'b0;
        push0_adel = 1'b0;
        push1_adel = 1'b0;
        pop_ready = 1'b0;
    endtask

    task automatic setPair(logic [31:0] pc, logic two);
        push0_valid = 1'b1;
        push0_pc = pc;
        push0_instr = pc ^ 32'h2400_0000;
        push0_adel = 1'b0;
        push1_valid = two;
        push1_pc = pc + 32'd4;
        push1_instr = (pc + 32'd4) ^ 32'h2400_0000;
        push1_adel = 1'b0;
    endtask

    task automatic doFlush();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int popPct;
        #1 rst = 1'b1;
        #1 cmpEn = 1'b1;
        repeat (2) step();
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_instr", 64'(out_instr), 64'(0));
        check("rst_adel", 64'(out_adel), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_ready", 64'(fifo_ready), 64'(1));
        check("rst_pc", 64'(out_pc), 64'(0));
        rst = 1'b0;

        push0_valid = 1'b1;
        push0_pc = 32'hBFC0_0000;
        push0_instr = 32'h2408_0001;
        step();
        idle();
        check("single_valid", 64'(out_valid), 64'(1));
        check("single_instr", 64'(out_instr), 64'h2408_0001);
        check("single_count", 64'(count), 64'(1));
        check("single_pc", 64'(out_pc), 64'hBFC0_0000);

        // Fill to 7, stall, pop once, then drain leaving the write pointer at 7.
        doFlush();
        for (int k = 0; k < 3; k++) begin
            setPair(32'h10 + 32'(k * 8), 1'b1);
            step();
        end
        setPair(32'h40, 1'b0);
        step();
        check("full_count7", 64'(count), 64'(7));
        check("full_ready0", 64'(fifo_ready), 64'(0));
        setPair(32'h50, 1'b1);
        step();
        check("full_ignored", 64'(count), 64'(7));
        idle();
        pop_ready = 1'b1;
        step();
        check("full_pop_count", 64'(count), 64'(6));
        check("full_pop_ready", 64'(fifo_ready), 64'(1));
        repeat (6) step();
        check("wrap_empty", 64'(count), 64'(0));
        check("wrap_wr7", 64'(dut.wrPtr), 64'(7));
        idle();
        setPair(32'h100, 1'b1);
        step();
        idle();
        check("wrap_wr1", 64'(dut.wrPtr), 64'(1));
        check("wrap_head0", 64'(out_pc), 64'h100);
        pop_ready = 1'b1;
        step();
        check("wrap_head1", 64'(out_pc), 64'h104);
        step();
        idle();

        doFlush();
        for (int k = 0; k < 4; k++) begin
            setPair(32'h300 + 32'(k * 8), 1'b1);
            step();
        end
        idle();
        check("full8_count", 64'(count), 64'(8));
        check("full8_ready", 64'(fifo_ready), 64'(0));
        setPair(32'h380, 1'b1);
        pop_ready = 1'b1;
        step();
        idle();
        check("full8_pop_push", 64'(count), 64'(7));

        doFlush();
        setPair(32'h200, 1'b1);
        step();
        setPair(32'h208, 1'b0);
        step();
        setPair(32'h20C, 1'b1);
        pop_ready = 1'b1;
        step();
        idle();
        check("push2pop_count", 64'(count), 64'(4));
        check("push2pop_head", 64'(out_pc), 64'h204);

        setPair(32'h214, 1'b0);
        step();
        check("flush_pre", 64'(count), 64'(5));
        setPair(32'h218, 1'b1);
        pop_ready = 1'b1;
        flush = 1'b1;
        step();
        idle();
        check("flush_count", 64'(count), 64'(0));
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_instr", 64'(out_instr), 64'(0));

        push0_valid = 1'b1;
        push0_pc = 32'h1234;
        push0_instr = 32'hFFFF_FFFF;
        push0_adel = 1'b1;
        step();
        idle();
        check("adel_flag", 64'(out_adel), 64'(1));
        check("adel_instr", 64'(out_instr), 64'(0));
        check("adel_pc", 64'(out_pc), 64'h1234);
        pop_ready = 1'b1;
        step();
        idle();

        push1_valid = 1'b1;
        push1_pc = 32'h7777;
        step();
        idle();
        check("lone_slot1", 64'(count), 64'(0));

        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 0) popPct = $urandom_range(10, 90);
            flush = ($urandom_range(0, 59) == 0);
            push0_valid = ($urandom_range(0, 3) != 0);
            push1_valid = $urandom_range(0, 1) == 1;
            push0_pc = $urandom;
            push0_instr = $urandom;
            push0_adel = ($urandom_range(0, 7) == 0);
            push1_pc = $urandom;
            push1_instr = $urandom;
            push1_adel = ($urandom_range(0, 7) == 0);
            pop_ready = ($urandom_range(0, 99) < popPct);
            step();
        end

        doFlush();
        setPair(32'h400, 1'b1);
        step();
        setPair(32'h408, 1'b1);
        step();
        idle();
        check("arst_pre", 64'(count), 64'(4));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'(0));
        check("arst_valid", 64'(out_valid), 64'(0));
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Fetch-to-decode instruction queue. It accepts up to two fetched instructions per cycle from the instruction-cache side and presents one instruction per cycle, show-ahead, to the main decoder as `instrD` plus its PC and fetch-exception flag. It decouples I-cache latency from decode stalls and drops all queued work on a pipeline flush (exception, eret, branch mispredict).

## Interface
Parameters:
- `DEPTH`, 8: number of entries. Must be a power of two and ≥ 4.
- `ADDR_W`, `$clog2(DEPTH)`: pointer width. Derived; do not override.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `flush`  in  1  discard all entries. Highest priority.
- `push0_valid`  in  1  slot-0 instruction present (older of the pair).
- `push0_pc`  in  32  slot-0 PC.
- `push0_instr`  in  32  slot-0 instruction word.
- `push0_adel`  in  1  slot-0 fetch address error.
- `push1_valid`, `push1_pc`, `push1_instr`, `push1_adel`  in  1/32/32/1  slot-1 (younger) fields, same meaning as slot 0.
- `fifo_ready`  out  1  queue can accept two entries this cycle.
- `pop_ready`  in  1  decode consumes the head this cycle (`~stallD`).
- `out_valid`  out  1  head entry valid.
- `out_pc`  out  32  head PC.
- `out_instr`  out  32  head instruction, fed to decoder `instrD`.
- `out_adel`  out  1  head fetch address error.
- `count`  out  ADDR_W+1  number of occupied entries.

## Operation
- Storage: circular buffer of DEPTH entries, each holding {pc[31:0], instr[31:0], adel}. State is `wr_ptr`, `rd_ptr` (ADDR_W bits, wrap modulo DEPTH) and `count`.
- Push:
  - Accepted only when `fifo_ready` = 1, i.e. registered `count` ≤ DEPTH−2.
  - Slot 0 is written at `wr_ptr`, slot 1 at `wr_ptr+1`.
  - `wr_ptr` and `count` advance by the number of valid slots (0/1/2).
  - `push1_valid` without `push0_valid` is a protocol error. Slot 1 is dropped and nothing is written.
  - Pushes while `fifo_ready` = 0 are ignored. The writer must hold its data.
- Pop: occurs when `out_valid & pop_ready`. `rd_ptr` advances by 1 and `count` decrements.
- Simultaneous push and pop: both take effect. `count_next = count + pushes − pop`.
- `fifo_ready` depends only on registered `count`, not on the same-cycle pop. There is no combinational path from `pop_ready` to `fifo_ready`.
- Output (show-ahead):
  - `out_valid = (count != 0)`. `out_pc` and `out_adel` come from the entry at `rd_ptr`.
  - `out_instr` is forced to 32'h0 (NOP) when `out_valid` = 0 or when the head `adel` = 1. This stops the decoder from raising a reserved-instruction fault on garbage. `out_pc` is still driven from the head when `adel` = 1.
- Flush: next cycle `wr_ptr = rd_ptr = 0` and `count = 0`. Any same-cycle push or pop is discarded. Stored data need not be cleared.
- Reset: pointers 0 and `count` 0. Outputs: `out_valid` 0, `out_instr` 0, `out_adel` 0, `count` 0, `fifo_ready` 1. `out_pc` reads the entry storage, which is also reset to 0.

## Timing
- Latency: an entry pushed in cycle N is visible on `out_*` in cycle N+1. There is no empty-queue bypass.
- Throughput: 1 pop per cycle sustained. Up to 2 pushes per cycle while `count` ≤ DEPTH−2.
- Full boundary:
  - At `count` = DEPTH−1 or DEPTH, `fifo_ready` = 0, even if a pop happens that cycle.
  - `count` never exceeds DEPTH.
- Empty boundary: with `count` = 0, `pop_ready` has no effect. A push in that cycle yields `count` = pushes.
- Wrap-around: a 2-entry push at `wr_ptr` = DEPTH−1 writes entries DEPTH−1 and 0, and `wr_ptr` becomes 1.
- Flush vs reset: `rst` overrides `flush` asynchronously. `flush` is synchronous.
- Reset mid-operation: all state returns to the reset values above immediately, independent of `clk`.

## Test plan
- **Reset then single push:** assert `rst`; release; push0 {pc=0xBFC00000, instr=0x24080001}.
  - Expect cycle+1: `out_valid` 1, `out_instr` 0x24080001, `count` 1.
- **Dual push with wrap:** with DEPTH=8, fill to `wr_ptr` = 7 via pushes/pops, then push two entries (pc 0x100, 0x104).
  - Expect them popped in order 0x100 then 0x104, and `wr_ptr` = 1.
- **Full and stall:**
  - Hold `pop_ready` 0 and push pairs until `count` = 7. Expect `fifo_ready` 0.
  - Further pushes are ignored; `count` stays 7.
  - Pop once. Expect `fifo_ready` 1 the following cycle.
- **Simultaneous push2 + pop at count=3:** expect `count` 4, and the head advances to the next PC.
- **Flush with concurrent push/pop at count=5:** expect next cycle `count` 0, `out_valid` 0, `out_instr` 0.
- **ADEL entry:** push0_adel=1 with instr=0xFFFFFFFF.
  - Expect `out_adel` 1, `out_instr` 0, `out_pc` equal to the pushed pc.
- **Async reset mid-operation:** assert `rst` between clock edges with `count` = 4.
  - Expect `count` 0 and `out_valid` 0 before the next clock edge.
